// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit scheduler.
//   state_t      : FSM state encoding
//   *_UNITS      : element and gap lengths in Morse units
//   ASCII_*      : character range limits used by the accept filter
//   lut_entry_t  : {is_space, len[2:0], pattern[4:0]} LUT entry (LUT_W bits)
//   char_ok / fold_upper / mk_entry : filter, case folding and LUT helper
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, MARK, GAP, LETTER_GAP, WORD_GAP
  } state_t;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int GAP_UNITS        = 1;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS   = 4;

  localparam logic [7:0] ASCII_UP_A = 8'h41;
  localparam logic [7:0] ASCII_UP_Z = 8'h5A;
  localparam logic [7:0] ASCII_LO_A = 8'h61;
  localparam logic [7:0] ASCII_LO_Z = 8'h7A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

  localparam int LUT_W = 9;

  typedef struct packed {
    logic       is_space;
    logic [2:0] len;
    logic [4:0] pattern;   // LSB = first element, 1 = dash
  } lut_entry_t;

  function automatic logic char_ok(input logic [7:0] c);
    return (c >= ASCII_UP_A && c <= ASCII_UP_Z) ||
           (c >= ASCII_LO_A && c <= ASCII_LO_Z) ||
           (c >= ASCII_0 && c <= ASCII_9) ||
           (c == ASCII_SP) || (c == ASCII_NL);
  endfunction

  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    return (c >= ASCII_LO_A && c <= ASCII_LO_Z) ? (c - 8'h20) : c;
  endfunction

  // Table entries are written in reading order (first element in the MSB of
  // the len-bit code); bit-reverse and right-align so element 0 is the LSB.
  function automatic lut_entry_t mk_entry(input logic [2:0] len, input logic [4:0] code);
    lut_entry_t e;
    logic [4:0] rev;
    rev       = {code[0], code[1], code[2], code[3], code[4]};
    e.is_space = 1'b0;
    e.len      = len;
    e.pattern  = rev >> (3'd5 - len);
    return e;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code table.
//   char_in : upper-case ASCII character (A-Z, 0-9, space, newline)
//   lut_out : {is_space, len[2:0], pattern[4:0]}; all zero for other codes
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0]       char_in,
  output logic [LUT_W-1:0] lut_out
);

  lut_entry_t e;

  always_comb begin
    e = '0;
    case (char_in)
      8'h41: e = mk_entry(3'd2, 5'b00001); // A .-
      8'h42: e = mk_entry(3'd4, 5'b01000); // B -...
      8'h43: e = mk_entry(3'd4, 5'b01010); // C -.-.
      8'h44: e = mk_entry(3'd3, 5'b00100); // D -..
      8'h45: e = mk_entry(3'd1, 5'b00000); // E .
      8'h46: e = mk_entry(3'd4, 5'b00010); // F ..-.
      8'h47: e = mk_entry(3'd3, 5'b00110); // G --.
      8'h48: e = mk_entry(3'd4, 5'b00000); // H ....
      8'h49: e = mk_entry(3'd2, 5'b00000); // I ..
      8'h4A: e = mk_entry(3'd4, 5'b00111); // J .---
      8'h4B: e = mk_entry(3'd3, 5'b00101); // K -.-
      8'h4C: e = mk_entry(3'd4, 5'b00100); // L .-..
      8'h4D: e = mk_entry(3'd2, 5'b00011); // M --
      8'h4E: e = mk_entry(3'd2, 5'b00010); // N -.
      8'h4F: e = mk_entry(3'd3, 5'b00111); // O ---
      8'h50: e = mk_entry(3'd4, 5'b00110); // P .--.
      8'h51: e = mk_entry(3'd4, 5'b01101); // Q --.-
      8'h52: e = mk_entry(3'd3, 5'b00010); // R .-.
      8'h53: e = mk_entry(3'd3, 5'b00000); // S ...
      8'h54: e = mk_entry(3'd1, 5'b00001); // T -
      8'h55: e = mk_entry(3'd3, 5'b00001); // U ..-
      8'h56: e = mk_entry(3'd4, 5'b00001); // V ...-
      8'h57: e = mk_entry(3'd3, 5'b00011); // W .--
      8'h58: e = mk_entry(3'd4, 5'b01001); // X -..-
      8'h59: e = mk_entry(3'd4, 5'b01011); // Y -.--
      8'h5A: e = mk_entry(3'd4, 5'b01100); // Z --..
      8'h30: e = mk_entry(3'd5, 5'b11111); // 0
      8'h31: e = mk_entry(3'd5, 5'b01111); // 1
      8'h32: e = mk_entry(3'd5, 5'b00111); // 2
      8'h33: e = mk_entry(3'd5, 5'b00011); // 3
      8'h34: e = mk_entry(3'd5, 5'b00001); // 4
      8'h35: e = mk_entry(3'd5, 5'b00000); // 5
      8'h36: e = mk_entry(3'd5, 5'b10000); // 6
      8'h37: e = mk_entry(3'd5, 5'b11000); // 7
      8'h38: e = mk_entry(3'd5, 5'b11100); // 8
      8'h39: e = mk_entry(3'd5, 5'b11110); // 9
      8'h20, 8'h0A: e = '{is_space: 1'b1, len: 3'd0, pattern: 5'd0};
      default: e = '0;
    endcase
  end

  assign lut_out = e;

endmodule

// File: rtl/morse_tx_scheduler.sv
// Morse playback scheduler: filters UART bytes into a character FIFO and, on a
// send press, plays the whole FIFO (including bytes arriving meanwhile) on key_out.
//   clk, rst        : clock, asynchronous active-low reset
//   rx_data/rx_valid: received byte and its one-cycle strobe
//   send            : debounced send button (level; rising edge starts playback)
//   key_out         : registered key, 1 while a dot/dash is sounding
//   busy / ready    : playback in progress / FIFO non-empty and idle
//   full / count    : FIFO full flag and occupancy
//   drop_err        : sticky drop flag, cleared by an accepted send
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_000_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          send,
  output logic                          key_out,
  output logic                          busy,
  output logic                          ready,
  output logic                          full,
  output logic                          drop_err,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(UNIT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [7:0]       char_reg;
  logic             send_q_reg;
  logic [2:0]       len_reg, len_next, elem_reg, elem_next;
  logic [4:0]       pattern_reg, pattern_next;
  logic [CNT_W-1:0] cyc_reg, cyc_next;
  logic [2:0]       units_reg, units_next;
  logic             key_reg, drop_err_reg;
  logic [LUT_W-1:0] lut_raw;
  lut_entry_t       lut_e;

  logic       rx_ok, push, drop, pop, send_edge, start, timer_done;
  logic [7:0] rx_char;
  logic [2:0] elem_inc;

  morse_lut u_lut (
    .char_in (char_reg),
    .lut_out (lut_raw)
  );
  assign lut_e = lut_entry_t'(lut_raw);

  assign rx_ok      = char_ok(rx_data);
  assign rx_char    = fold_upper(rx_data);
  assign full       = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign push       = rx_valid & rx_ok & ~full;
  assign drop       = rx_valid & (~rx_ok | full);
  // FETCH is only entered with count>0, so a pop never hits an empty FIFO.
  assign pop        = (state_reg == FETCH);
  assign send_edge  = send & ~send_q_reg;
  assign start      = send_edge & (state_reg == IDLE) & (count_reg != '0);
  assign elem_inc   = elem_reg + 3'd1;

  // The n-unit timer is split into a cycle counter (one unit) and a unit
  // counter, so CNT_W only has to hold UNIT_CYCLES-1 rather than n*UNIT_CYCLES-1.
  assign timer_done = (cyc_reg == '0) && (units_reg == '0);

  always_comb begin
    state_next   = state_reg;
    elem_next    = elem_reg;
    len_next     = len_reg;
    pattern_next = pattern_reg;
    if (cyc_reg == '0) begin
      cyc_next   = CYC_LAST;
      units_next = units_reg - 3'd1;
    end else begin
      cyc_next   = cyc_reg - 1'b1;
      units_next = units_reg;
    end

    case (state_reg)
      IDLE: if (start) state_next = FETCH;
      FETCH: state_next = LOAD;
      LOAD: begin
        len_next     = lut_e.len;
        pattern_next = lut_e.pattern;
        elem_next    = 3'd0;
        cyc_next     = CYC_LAST;
        if (lut_e.is_space) begin
          state_next = WORD_GAP;
          units_next = 3'(WORD_GAP_UNITS - 1);
        end else begin
          state_next = MARK;
          units_next = lut_e.pattern[0] ? 3'(DASH_UNITS - 1) : 3'(DOT_UNITS - 1);
        end
      end
      MARK: if (timer_done) begin
        cyc_next = CYC_LAST;
        if (elem_reg < len_reg - 3'd1) begin
          state_next = GAP;
          units_next = 3'(GAP_UNITS - 1);
        end else begin
          state_next = LETTER_GAP;
          units_next = 3'(LETTER_GAP_UNITS - 1);
        end
      end
      GAP: if (timer_done) begin
        state_next = MARK;
        elem_next  = elem_inc;
        cyc_next   = CYC_LAST;
        units_next = pattern_reg[elem_inc] ? 3'(DASH_UNITS - 1) : 3'(DOT_UNITS - 1);
      end
      LETTER_GAP, WORD_GAP: if (timer_done) begin
        state_next = (count_reg != '0) ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      send_q_reg   <= 1'b0;
      len_reg      <= '0;
      elem_reg     <= '0;
      pattern_reg  <= '0;
      cyc_reg      <= '0;
      units_reg    <= '0;
      key_reg      <= 1'b0;
      drop_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      send_q_reg  <= send;
      len_reg     <= len_next;
      elem_reg    <= elem_next;
      pattern_reg <= pattern_next;
      cyc_reg     <= cyc_next;
      units_reg   <= units_next;
      key_reg     <= (state_next == MARK);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      // A drop in the same cycle as an accepted send keeps the flag set.
      if (drop)       drop_err_reg <= 1'b1;
      else if (start) drop_err_reg <= 1'b0;
    end
  end

  // Storage has no reset so it maps onto RAM; emptiness is tracked by pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= rx_char;
    if (pop)  char_reg <= fifo_mem[rd_ptr_reg];
  end

  assign key_out  = key_reg;
  assign busy     = (state_reg != IDLE);
  assign ready    = (count_reg != '0) && (state_reg == IDLE);
  assign drop_err = drop_err_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
module tb_morse_tx_scheduler;

  localparam int UNIT  = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       send = 1'b0;
  logic       key_out, busy, ready, full, drop_err;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one expected key_out value per busy cycle, in playback order.
  bit sb[$];
  int model_count = 0;
  bit model_drop  = 1'b0;
  string pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789 \n";

  always #5 clk = ~clk;

  morse_tx_scheduler #(.UNIT_CYCLES(UNIT), .FIFO_DEPTH(DEPTH), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .send(send),
    .key_out(key_out), .busy(busy), .ready(ready), .full(full),
    .drop_err(drop_err), .count(count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit accepts(input logic [7:0] b);
    return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z") ||
           (b >= "0" && b <= "9") || b == 8'h20 || b == 8'h0A;
  endfunction

  function automatic logic [7:0] upcase(input logic [7:0] b);
    return (b >= "a" && b <= "z") ? b - 8'd32 : b;
  endfunction

  function automatic string morse_of(input logic [7:0] c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Expected key waveform for one character: two quiet cycles to fetch and
  // decode it, then the elements, then the trailing letter or word gap.
  task automatic push_char(input logic [7:0] c);
    string m;
    byte   s;
    repeat (2) sb.push_back(1'b0);
    if (c == 8'h20 || c == 8'h0A) begin
      repeat (4 * UNIT) sb.push_back(1'b0);
      return;
    end
    m = morse_of(c);
    for (int i = 0; i < m.len(); i++) begin
      s = m[i];
      if (i > 0) repeat (UNIT) sb.push_back(1'b0);
      repeat ((s == "-") ? 3 * UNIT : UNIT) sb.push_back(1'b1);
    end
    repeat (3 * UNIT) sb.push_back(1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (accepts(b) && model_count < DEPTH) begin
      model_count++;
      push_char(upcase(b));
    end else begin
      model_drop = 1'b1;
    end
    $display("rx 0x%02h -> count=%0d drop_err=%0b full=%0b", b, count, drop_err, full);
    chk("rx_count", int'(count), model_count);
    chk("rx_drop_err", int'(drop_err), int'(model_drop));
    chk("rx_full", int'(full), int'(model_count == DEPTH));
    chk("rx_ready", int'(ready), int'(model_count > 0));
  endtask

  task automatic do_send(input bit expect_start);
    send = 1'b1;
    tick();
    send = 1'b0;
    if (expect_start) begin
      model_count = 0;
      model_drop  = 1'b0;
    end
    $display("send -> busy=%0b drop_err=%0b", busy, drop_err);
    chk("send_busy", int'(busy), int'(expect_start));
    chk("send_drop_err", int'(drop_err), int'(model_drop));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    $display("burst done after %0d cycles: count=%0d ready=%0b", n, count, ready);
    chk("burst_ends", int'(busy), 0);
    chk("idle_count", int'(count), 0);
    chk("idle_ready", int'(ready), 0);
    tick();
  endtask

  // Monitor: consumes one expected key value per busy cycle.
  initial begin
    bit busy_prev = 1'b0;
    bit e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (busy) begin
          chk("key_expected_activity", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("key_out", int'(key_out), int'(e));
          end
        end else if (busy_prev) begin
          chk("key_remaining_at_idle", sb.size(), 0);
        end
        busy_prev = busy;
      end else begin
        busy_prev = 1'b0;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int l1;

    // Reset state
    repeat (3) tick();
    chk("rst_key", int'(key_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_drop", int'(drop_err), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b1;
    tick();

    // Single dot, lower-case folding, word gap between letters
    rx_byte(8'h45); do_send(1'b1); wait_idle(500);
    rx_byte(8'h61); do_send(1'b1); wait_idle(500);
    rx_byte(8'h45); rx_byte(8'h20); rx_byte(8'h45); do_send(1'b1); wait_idle(500);

    // Rejected byte, send with empty FIFO is ignored
    rx_byte(8'h23);
    do_send(1'b0);
    repeat (4) tick();
    chk("empty_send_busy", int'(busy), 0);
    chk("empty_send_drop", int'(drop_err), 1);

    // Fill, overflow, push coinciding with the second FETCH pop
    for (int i = 0; i < DEPTH; i++) begin
      b = pool[$urandom_range(0, pool.len() - 1)];
      rx_byte(b);
      if (i == 0) l1 = sb.size();
    end
    rx_byte(8'h4B);
    do_send(1'b1);
    chk("fetch1_count", int'(count), DEPTH);
    repeat (l1) tick();
    chk("fetch2_count_before", int'(count), DEPTH - 1);
    rx_data = 8'h5A; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    push_char(8'h5A);
    $display("rx during fetch -> count=%0d", count);
    chk("fetch2_count_after", int'(count), DEPTH - 1);
    wait_idle(4000);

    // Randomized bursts
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 3) != 0) b = pool[$urandom_range(0, pool.len() - 1)];
        else b = 8'($urandom_range(0, 255));
        rx_byte(b);
      end
      do_send(model_count > 0);
      wait_idle(3000);
    end

    // Asynchronous reset in the middle of a dash
    rx_byte(8'h54);
    do_send(1'b1);
    repeat (7) tick();
    chk("dash_on", int'(key_out), 1);
    #2;
    rst = 1'b0;
    sb.delete();
    model_count = 0;
    model_drop  = 1'b0;
    #1;
    $display("async reset -> key_out=%0b busy=%0b count=%0d", key_out, busy, count);
    chk("arst_key", int'(key_out), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    do_send(1'b0);
    repeat (5) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_key", int'(key_out), 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
